// File: rtl/ialm_pkg.sv
// Shared definitions for the iterative approximate logarithmic multiplier (IALM).
// Holds default sizing, the controller state type and the per-iteration term.
package ialm_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ITER  = 2;
  localparam int KW        = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // One Mitchell term: 2^(k1+k2) + (r1<<k2) + (r2<<k1), all zero-extended to the product width.
  function automatic logic [2*DEF_WIDTH-1:0] iter_term(
    input logic [KW-1:0]        k1,
    input logic [KW-1:0]        k2,
    input logic [DEF_WIDTH-1:0] r1,
    input logic [DEF_WIDTH-1:0] r2
  );
    logic [KW:0]              ks;
    logic [2*DEF_WIDTH-1:0]   pow;
    ks  = {1'b0, k1} + {1'b0, k2};
    pow = {{(2*DEF_WIDTH-1){1'b0}}, 1'b1} << ks;
    return pow + ({{DEF_WIDTH{1'b0}}, r1} << k2) + ({{DEF_WIDTH{1'b0}}, r2} << k1);
  endfunction

endpackage

// File: rtl/ialm_lod.sv
// Combinational leading-one detector: position of the highest set bit of x,
// plus a flag for the all-zero input (k is 0 in that case).
module ialm_lod
  import ialm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]         x,
  output logic [$clog2(WIDTH)-1:0] k,
  output logic                     zero
);

  localparam int KB = $clog2(WIDTH);

  // NOTE: k is given a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) k = i[KB-1:0];
    end
  end

  assign zero = ~|x;

endmodule

// File: rtl/ialm_iter_ctrl.sv
// Sequential IALM controller: accepts an operand pair, runs up to ITER Mitchell
// iterations (one per clock) and returns the accumulated approximate product.
module ialm_iter_ctrl
  import ialm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = DEF_ITER
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH-1:0]         product,
  output logic [$clog2(ITER+1)-1:0]  iter_used,
  output logic                       busy
);

  localparam int              KB     = $clog2(WIDTH);
  localparam int              CW     = $clog2(ITER+1);
  localparam logic [CW-1:0]   ITER_C = CW'(ITER);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       x1, x2, r1, r2;
  logic [KB-1:0]          k1, k2;
  logic                   z1, z2;
  logic [2*WIDTH-1:0]     acc, term;
  logic [2*DEF_WIDTH-1:0] term_full;
  logic [CW-1:0]          cnt, cnt_inc;
  logic                   accept, step, last;

  ialm_lod #(.WIDTH(WIDTH)) u_lod1 (.x(x1), .k(k1), .zero(z1));
  ialm_lod #(.WIDTH(WIDTH)) u_lod2 (.x(x2), .k(k2), .zero(z2));

  always_comb begin
    r1     = x1;
    r1[k1] = 1'b0;
    r2     = x2;
    r2[k2] = 1'b0;
  end

  assign term_full = iter_term(KW'(k1), KW'(k2), DEF_WIDTH'(r1), DEF_WIDTH'(r2));
  assign term      = (2*WIDTH)'(term_full);
  assign cnt_inc   = cnt + 1'b1;
  // A zero residual means the next iteration would add nothing, so finish now.
  assign last      = (cnt_inc == ITER_C) || (r1 == '0) || (r2 == '0);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    in_ready  = (state_q == IDLE);
    busy      = (state_q == CALC);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = (a == '0 || b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (z1 || z2) begin
          state_d = DONE;
        end else begin
          step = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every datapath register is reset so an aborted transaction leaves nothing visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      x1  <= '0;
      x2  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      x1  <= a;
      x2  <= b;
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      acc <= acc + term;
      x1  <= r1;
      x2  <= r2;
      cnt <= cnt_inc;
    end
  end

  assign product   = acc;
  assign iter_used = cnt;

endmodule

// File: doc/ialm_iter_ctrl.md
Name: ialm_iter_ctrl

Overview:
- Sequential controller for the iterative approximate logarithmic multiplier (IALM).
- Accepts one operand pair per transaction over a valid/ready handshake and runs up to ITER Mitchell iterations, one per clock.
- Each iteration takes the leading-one positions k1 and k2, adds the term 2^(k1+k2) + (r1<<k2) + (r2<<k1) to an accumulator, then replaces the operands with their residuals.
- Returns the accumulated product over an output valid/ready handshake. Sits between the operand source and the downstream consumer of the approximate product.

Parameters:
- WIDTH, 16, operand width; product width is 2*WIDTH.
- ITER, 2, maximum number of iterations (legal range 1..WIDTH). ITER=1 is plain Mitchell.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept (high only in IDLE).
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  product valid (high only in DONE).
- out_ready  in  1  consumer takes the product.
- product  out  2*WIDTH  accumulated approximate product.
- iter_used  out  clog2(ITER+1)  number of iterations that added a term.
- busy  out  1  high in CALC.

Behaviour:
- Reset: state IDLE. in_ready=1, out_valid=0, busy=0, product=0, iter_used=0. Operand, residual and count registers are cleared.
- rst asserted in any state, including mid-CALC or DONE, discards the transaction and returns to IDLE on that edge.
- IDLE: in_ready=1. On the edge where in_valid&&in_ready: latch x1<=a, x2<=b, acc<=0, cnt<=0, then go to CALC.
- CALC, one cycle per iteration:
  - If x1==0 or x2==0: go to DONE; acc and cnt are unchanged.
  - Otherwise: k1=LOD(x1), k2=LOD(x2), r1=x1 with bit k1 cleared, r2=x2 with bit k2 cleared.
  - acc<=acc+(1<<(k1+k2))+(r1<<k2)+(r2<<k1); x1<=r1; x2<=r2; cnt<=cnt+1.
  - If cnt+1==ITER, go to DONE; otherwise stay in CALC.
- DONE: out_valid=1, product=acc, iter_used=cnt. These outputs are registered and held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE. The next pair can be accepted no earlier than the following cycle; there is no same-cycle turnaround.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - n+1 cycles when n iterations run to ITER.
  - n+1 cycles on zero-residual early exit, where n is the number of iterations that added a term. A zero operand gives 1 cycle.
- Width rules:
  - k1 and k2 are clog2(WIDTH) bits; their sum is clog2(WIDTH)+1 bits.
  - All terms are zero-extended to 2*WIDTH before addition.
  - acc never exceeds a*b (each term underestimates the remaining product), so no overflow or saturation logic is required.
- in_valid while not in IDLE is ignored; a and b are sampled only on the accept edge.
- The product in DONE is exact when the residuals reach zero within ITER iterations.

Decomposition:
- Package ialm_pkg holds:
  - default WIDTH and ITER;
  - KW=clog2(WIDTH);
  - the state enum {IDLE, CALC, DONE};
  - a function computing the iteration term from (k1, k2, r1, r2).
- Sub-module ialm_lod: combinational leading-one detector. Input x[WIDTH]; outputs k[KW] and zero flag. It is instantiated twice, for x1 and x2. All sequencing stays in ialm_iter_ctrl.

Test Plan:
- ITER=1, a=3, b=3: product=8, iter_used=1, out_valid 2 cycles after accept. ITER=2, same operands: product=9, iter_used=2, latency 3.
- ITER=2, a=15, b=15: product=216. ITER=4, same operands: product=225 (exact), iter_used=4, latency 5.
- ITER=4, a=8, b=5: iteration 1 gives 40 and residual x1=0, so early exit. product=40, iter_used=1, out_valid 2 cycles after accept.
- a=0, b=1234: product=0, iter_used=0, out_valid 1 cycle after accept. a=0xFFFF, b=0xFFFF with ITER=WIDTH: product=0xFFFE0001.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_valid with new operands. Required: product, iter_used and out_valid stay stable, in_ready=0, and the new operands are not accepted. Release out_ready: IDLE next cycle, in_ready=1.
- Reset mid-CALC (ITER=4, a=b=15, rst high in the second CALC cycle): next cycle state is IDLE, out_valid=0, product=0, in_ready=1. A following pair a=b=3 with ITER=4 yields 9.
